serial_display_rx: RTL and testbench
====================================

Name: serial_display_rx

Overview:
- Receiving end of the clock's serial display link: consumes the output shift stage's serial clock, latch and data lines in the system clock domain.
- Deserialises each frame and presents the latched display word, 74HC595-chain style.
- Adds frame-length checking.
- Used as the on-chip loopback monitor and as the bench's golden receiver for the display path.

Parameters:
- FRAME_BITS, 48, serial bits per latched frame (6 digits x 8 segment bits).
- SYNC_STAGES, 2, synchroniser flops on i_sclk/i_latch/i_bit (0 = sample directly, no synchroniser).
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low; deassertion is sampled on i_clk.
- i_sclk  input  1  serial shift clock from the output shift stage.
- i_latch  input  1  frame latch strobe.
- i_bit  input  1  serial data, valid at the i_sclk rising edge.
- o_frame  output  FRAME_BITS  last latched frame; the first bit shifted lands in the MSB.
- o_valid  output  1  one-cycle pulse when o_frame updates.
- o_frame_err  output  1  high while the last latched frame had a wrong bit count.
- o_bit_cnt  output  clog2(FRAME_BITS+1)  bits shifted since the last latch, saturating.
- o_err_cnt  output  ERR_W  count of bad frames, saturating.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all outputs and all internal state go to 0, including synchroniser and edge-detect history.
- Input path:
  - i_sclk, i_latch and i_bit pass through identical SYNC_STAGES flop chains, so they stay mutually aligned.
  - Each synchronised strobe is edge-detected against one further history flop.
  - A rising edge = previous 0, current 1.
- Shift: on a synchronised i_sclk rising edge:
  - sr <= {sr[FRAME_BITS-2:0], bit_sync}.
  - bit_cnt increments, saturating at FRAME_BITS+1 (any overrun is distinguishable from an exact frame).
- Latch: on a synchronised i_latch rising edge:
  - o_frame <= sr and o_valid=1 for exactly one cycle.
  - o_frame_err <= (bit_cnt != FRAME_BITS).
  - o_err_cnt increments if bad, saturating at 2^ERR_W-1.
  - bit_cnt <= 0; sr is NOT cleared.
- Latency: o_valid asserts SYNC_STAGES+1 cycles after the raw i_latch rising edge is sampled.
- o_frame, o_frame_err, o_err_cnt change only on a latch event; they hold otherwise.
- o_bit_cnt is a live view of bit_cnt.
- Simultaneous sclk and latch rising edges in the same cycle:
  - The shift happens first; the latched word and count include the new bit.
  - bit_cnt then restarts at 0 (the new bit belongs to the closed frame).
- Edge handling:
  - Levels held high do not retrigger.
  - i_sclk toggling while i_latch is high is shifted normally.
- Latch with zero bits since the last latch: o_frame = unchanged sr, o_frame_err=1.
- Minimum strobe width for detection: high and low each at least 1 i_clk cycle (the input stage produces multi-cycle strobes).
- Reset mid-frame: the partial frame is discarded, with no o_valid and no error count; the next frame is received from bit 0.
- State machine (per frame):
  - IDLE (bit_cnt=0) -> SHIFTING on the first sclk edge.
  - SHIFTING -> IDLE on a latch edge.
  - SHIFTING -> OVERRUN when bit_cnt reaches FRAME_BITS+1; OVERRUN -> IDLE on a latch edge.
  - Only IDLE/SHIFTING/OVERRUN are observable via o_bit_cnt.

Test Plan:
- 48 sclk edges carrying 0xA5_3C_0F_F0_81_7E (MSB first), then latch -> o_frame=0xA53C0FF0817E, o_valid pulse 3 cycles after the latch edge, o_frame_err=0, o_err_cnt=0.
- 47-bit frame then latch -> o_frame_err=1, o_err_cnt=1; following good 48-bit frame -> o_frame_err=0, o_err_cnt stays 1.
- 60 sclk edges -> o_bit_cnt saturates at 49; latch -> o_frame holds the last 48 bits shifted, o_frame_err=1.
- 47 edges, then the 48th sclk edge coincident with the latch edge -> frame accepted, o_frame_err=0, o_bit_cnt=0 afterwards.
- Reset pulsed after 20 bits, then a full 48-bit frame -> o_frame = the new frame only, o_err_cnt=0, no o_valid during reset.
- ERR_W=2, five bad frames -> o_err_cnt saturates at 3; two back-to-back latches -> second flagged as a bad frame with 0 bits.

Source files
------------

// File: rtl/serial_display_rx.sv
// serial_display_rx
// Receiving end of the serial display link. Samples the shift clock, latch
// strobe and serial data in the system clock domain, deserialises each frame
// and presents the latched display word (74HC595-chain style), with a
// frame-length check and a saturating bad-frame counter.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_sclk       serial shift clock from the output shift stage
//   i_latch      frame latch strobe
//   i_bit        serial data, valid at the i_sclk rising edge
//   o_frame      last latched frame, first shifted bit in the MSB
//   o_valid      one-cycle pulse when o_frame updates
//   o_frame_err  last latched frame had a wrong bit count
//   o_bit_cnt    bits shifted since the last latch, saturating at FRAME_BITS+1
//   o_err_cnt    saturating count of bad frames
module serial_display_rx #(
  parameter int FRAME_BITS  = 48,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8,
  localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_latch,
  input  logic                  i_bit,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic [CNT_W-1:0]      o_bit_cnt,
  output logic [ERR_W-1:0]      o_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_OVERRUN  = 2'd2
  } state_e;

  // {sclk, latch, bit} travel together so they stay mutually aligned.
  logic [2:0] raw_s;
  logic [2:0] in_s;
  assign raw_s = {i_sclk, i_latch, i_bit};

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [2:0] sync_q [SYNC_STAGES];

      // Synchroniser chain for the three link lines.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
        end else begin
          sync_q[0] <= raw_s;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign in_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign in_s = raw_s;
    end
  endgenerate

  logic [1:0] hist_q;  // previous {sclk, latch}
  logic       sclk_rise_s;
  logic       latch_rise_s;
  logic       bit_s;

  assign sclk_rise_s  = in_s[2] & ~hist_q[1];
  assign latch_rise_s = in_s[1] & ~hist_q[0];
  assign bit_s        = in_s[0];

  // Edge-detect history for the synchronised strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hist_q <= 2'b00;
    else          hist_q <= in_s[2:1];
  end

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic [ERR_W-1:0]        errcnt_q, errcnt_d;
  logic                    bad_s;

  // Next-state: shift first, then a coincident latch closes the frame
  // including the bit just shifted in.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    ferr_d   = ferr_q;
    errcnt_d = errcnt_q;
    bad_s    = 1'b0;

    if (sclk_rise_s) begin
      sr_d = {sr_q[FRAME_BITS-2:0], bit_s};
      case (state_q)
        ST_IDLE: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_SAT) ? ST_OVERRUN : ST_SHIFTING;
        end
        ST_SHIFTING: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_SAT) ? ST_OVERRUN : ST_SHIFTING;
        end
        ST_OVERRUN: begin
          cnt_d   = cnt_q;
          state_d = ST_OVERRUN;
        end
        default: begin
          cnt_d   = cnt_q;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      sr_d = sr_q;
    end

    if (latch_rise_s) begin
      bad_s   = (cnt_d != CNT_FULL);
      frame_d = sr_d;
      valid_d = 1'b1;
      ferr_d  = bad_s;
      if (bad_s && (errcnt_q != ERR_MAX)) errcnt_d = errcnt_q + ERR_W'(1);
      else                                errcnt_d = errcnt_q;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign o_frame     = frame_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_bit_cnt   = cnt_q;
  assign o_err_cnt   = errcnt_q;

endmodule

// File: tb/tb_serial_display_rx.sv
module tb_serial_display_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        latch = 1'b0;
  logic        bit_i = 1'b0;

  logic [47:0] frame1, frame2;
  logic        valid1, valid2, ferr1, ferr2;
  logic [5:0]  bcnt1, bcnt2;
  logic [7:0]  ecnt1;
  logic [1:0]  ecnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_display_rx u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_latch(latch), .i_bit(bit_i),
    .o_frame(frame1), .o_valid(valid1), .o_frame_err(ferr1),
    .o_bit_cnt(bcnt1), .o_err_cnt(ecnt1)
  );

  serial_display_rx #(.ERR_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_latch(latch), .i_bit(bit_i),
    .o_frame(frame2), .o_valid(valid2), .o_frame_err(ferr2),
    .o_bit_cnt(bcnt2), .o_err_cnt(ecnt2)
  );

  // Reference model: bit history and frame accounting
  typedef struct {
    logic [47:0] frame;
    logic        err;
    int          errn;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [47:0] m_sr = 48'd0;   // last 48 bits ever shifted since reset
  int          m_since = 0;    // bits since last latch
  int          m_errn = 0;     // bad frames since reset
  logic [47:0] held1 = 48'd0, held2 = 48'd0;
  int          held_e1 = 0, held_e2 = 0;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Scoreboard monitor: pops an expectation on each o_valid
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      chk("valid_in_reset", 64'(valid1 | valid2), 64'd0);
    end else begin
      if (valid1) begin
        chk("q1_has_entry", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("frame1", 64'(frame1), 64'(e.frame));
          chk("ferr1", 64'(ferr1), 64'(e.err));
          chk("ecnt1", 64'(ecnt1), 64'(sat(e.errn, 255)));
          held1 = e.frame;
          held_e1 = sat(e.errn, 255);
        end
      end else begin
        chk("hold_frame1", 64'(frame1), 64'(held1));
        chk("hold_ecnt1", 64'(ecnt1), 64'(held_e1));
      end
      if (valid2) begin
        chk("q2_has_entry", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("frame2", 64'(frame2), 64'(e.frame));
          chk("ferr2", 64'(ferr2), 64'(e.err));
          chk("ecnt2", 64'(ecnt2), 64'(sat(e.errn, 3)));
          held2 = e.frame;
          held_e2 = sat(e.errn, 3);
        end
      end else begin
        chk("hold_frame2", 64'(frame2), 64'(held2));
        chk("hold_ecnt2", 64'(ecnt2), 64'(held_e2));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_shift(input logic b);
    m_sr = {m_sr[46:0], b};
    m_since++;
  endtask

  task automatic shift_bit(input logic b);
    bit_i = b;
    sclk = 1'b1;
    model_shift(b);
    cyc(2);
    sclk = 1'b0;
    cyc(2);
  endtask

  // Latch, optionally with a coincident sclk edge carrying bit b.
  task automatic latch_frame(input logic with_bit, input logic b);
    exp_t e;
    int   lat;
    logic seen;
    if (with_bit) begin
      bit_i = b;
      sclk = 1'b1;
      model_shift(b);
    end
    e.frame = m_sr;
    e.err   = (m_since != 48);
    if (e.err) m_errn++;
    e.errn  = m_errn;
    q1.push_back(e);
    q2.push_back(e);
    m_since = 0;
    latch = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (lat < 10 && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid1) seen = 1'b1;
    end
    chk("valid_latency", 64'(lat), 64'd3);
    cyc(1);
    sclk = 1'b0;
    latch = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    chk("rst_frame", 64'(frame1), 64'd0);
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_ferr", 64'(ferr1), 64'd0);
    chk("rst_bcnt", 64'(bcnt1), 64'd0);
    chk("rst_ecnt", 64'(ecnt1), 64'd0);
    chk("rst_ecnt2", 64'(ecnt2), 64'd0);
    m_sr = 48'd0;
    m_since = 0;
    m_errn = 0;
    held1 = 48'd0;
    held2 = 48'd0;
    held_e1 = 0;
    held_e2 = 0;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic check_bcnt(input string nm);
    chk(nm, 64'(bcnt1), 64'(sat(m_since, 49)));
  endtask

  initial begin
    logic [47:0] pat;
    int          len;

    cyc(1);
    do_reset();

    // Known pattern, MSB first
    pat = 48'hA53C0FF0817E;
    for (int i = 47; i >= 0; i--) shift_bit(pat[i]);
    check_bcnt("bcnt_full");
    latch_frame(1'b0, 1'b0);
    chk("ferr_good", 64'(ferr1), 64'd0);

    // Short frame, then good frame
    for (int i = 0; i < 47; i++) shift_bit(1'($urandom_range(0, 1)));
    check_bcnt("bcnt_47");
    latch_frame(1'b0, 1'b0);
    chk("ferr_short", 64'(ferr1), 64'd1);
    for (int i = 0; i < 48; i++) shift_bit(1'($urandom_range(0, 1)));
    latch_frame(1'b0, 1'b0);
    chk("ferr_after_short", 64'(ferr1), 64'd0);

    // Overrun
    for (int i = 0; i < 60; i++) shift_bit(1'($urandom_range(0, 1)));
    check_bcnt("bcnt_sat");
    latch_frame(1'b0, 1'b0);
    chk("ferr_overrun", 64'(ferr1), 64'd1);

    // 48th bit coincident with latch
    for (int i = 0; i < 47; i++) shift_bit(1'($urandom_range(0, 1)));
    latch_frame(1'b1, 1'($urandom_range(0, 1)));
    chk("ferr_coincident", 64'(ferr1), 64'd0);
    chk("bcnt_after_coincident", 64'(bcnt1), 64'd0);

    // Reset mid-frame
    for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)));
    do_reset();
    pat = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    for (int i = 47; i >= 0; i--) shift_bit(pat[i]);
    latch_frame(1'b0, 1'b0);
    chk("frame_after_reset", 64'(frame1), 64'(pat));

    // Five bad frames saturate the 2-bit counter
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 10; i++) shift_bit(1'($urandom_range(0, 1)));
      latch_frame(1'b0, 1'b0);
    end
    chk("ecnt2_sat", 64'(ecnt2), 64'd3);
    chk("ecnt1_five", 64'(ecnt1), 64'd5);

    // Good frame then back-to-back latches
    for (int i = 0; i < 48; i++) shift_bit(1'($urandom_range(0, 1)));
    latch_frame(1'b0, 1'b0);
    latch_frame(1'b0, 1'b0);
    chk("ferr_zero_bits", 64'(ferr1), 64'd1);
    chk("ecnt1_zero_bits", 64'(ecnt1), 64'd6);

    // Randomised frames
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0:       len = 48;
        1:       len = 47;
        2:       len = 49;
        default: len = int'($urandom_range(0, 55));
      endcase
      for (int i = 0; i < len; i++) shift_bit(1'($urandom_range(0, 1)));
      check_bcnt("bcnt_rand");
      if ($urandom_range(0, 1) == 1 && len > 0) latch_frame(1'b1, 1'($urandom_range(0, 1)));
      else latch_frame(1'b0, 1'b0);
    end

    cyc(5);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
